alignment_collector: RTL and testbench

- Sits directly downstream of the traceback stage.
- Consumes the per-cycle alignment symbol stream (alignment_out / alignment_valid / done), packs symbols into fixed-width words and buffers them in a small FIFO.
- Presents the words to the host over a valid/ready handshake with a last flag and a partial-word count.
- Counts the alignment length and flags overflow, because the traceback stage cannot be back-pressured.

---
 rtl/alignment_collector_pkg.sv | 22 ++
 rtl/aln_sync_fifo.sv | 52 +++++
 rtl/alignment_collector.sv | 149 ++++++++++++++
 tb/tb_alignment_collector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alignment_collector_pkg.sv
// Shared definitions for the alignment collector: symbol codes, default sizes
// and the control state encoding.
package alignment_collector_pkg;

  localparam int ALN_BP_WIDTH       = 2;
  localparam int ALN_PACK           = 16;
  localparam int ALN_OUT_FIFO_DEPTH = 8;
  localparam int ALN_LEN_WIDTH      = 16;

  localparam logic [1:0] ALN_MATCH    = 2'b00;
  localparam logic [1:0] ALN_MISMATCH = 2'b01;
  localparam logic [1:0] ALN_INS      = 2'b10;
  localparam logic [1:0] ALN_DEL      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DRAIN   = 2'd3
  } aln_state_e;

endpackage

// File: rtl/aln_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle, otherwise the push is discarded.
module aln_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alignment_collector.sv
// Packs the traceback symbol stream into PACK-symbol words, buffers them and
// hands them to the host with last/count framing and overflow tracking.
module alignment_collector
  import alignment_collector_pkg::*;
#(
  parameter int BP_WIDTH   = ALN_BP_WIDTH,
  parameter int PACK       = ALN_PACK,
  parameter int FIFO_DEPTH = ALN_OUT_FIFO_DEPTH,
  parameter int LEN_WIDTH  = ALN_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       tb_valid,
  input  logic [BP_WIDTH-1:0]        alignment_in,
  input  logic                       alignment_valid,
  input  logic                       done,
  output logic [PACK*BP_WIDTH-1:0]   out_data,
  output logic [$clog2(PACK):0]      out_count,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LEN_WIDTH-1:0]       total_len,
  output logic                       overflow,
  output logic                       busy
);

  localparam int WORD_W = PACK * BP_WIDTH;
  localparam int CNT_W  = $clog2(PACK) + 1;
  localparam int ENT_W  = WORD_W + CNT_W + 1;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  aln_state_e            r_state;
  aln_state_e            w_state_nxt;
  logic                  r_tb_prev;
  logic [WORD_W-1:0]     r_word;
  logic [CNT_W-1:0]      r_idx;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_ovf;

  logic                  w_rise;
  logic                  w_sym;
  logic                  w_held_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_push;
  logic                  w_push_last;
  logic [CNT_W-1:0]      w_push_cnt;
  logic [ENT_W-1:0]      w_push_data;
  logic [ENT_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  int                    w_lo;

  assign w_rise      = tb_valid & ~r_tb_prev;
  assign w_sym       = (r_state == ST_COLLECT) & alignment_valid;
  assign w_held_full = (r_idx == CNT_W'(PACK));
  assign w_pop       = ~w_empty & out_ready;
  assign w_push_ok   = ~w_full | w_pop;
  assign w_lo        = int'(r_idx) * BP_WIDTH;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_rise)    w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (done)      w_state_nxt = ST_FLUSH;
      ST_FLUSH:   if (w_push_ok) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_empty)   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // A full word is only released once the next symbol proves it is not the last.
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_cnt  = CNT_W'(PACK);
    case (r_state)
      ST_COLLECT: w_push = w_sym & w_held_full;
      ST_FLUSH: begin
        w_push      = 1'b1;
        w_push_last = 1'b1;
        w_push_cnt  = r_idx;
      end
      default: ;
    endcase
  end

  assign w_push_data = {w_push_last, w_push_cnt, r_word};

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_tb_prev <= 1'b0;
      r_word    <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_tb_prev <= tb_valid;
      if ((r_state == ST_IDLE) && w_rise) begin
        r_idx <= '0;
        r_len <= '0;
        r_ovf <= 1'b0;
      end else if (w_sym) begin
        r_len <= sat_inc(r_len);
        if (w_held_full || (r_idx == '0)) begin
          // Starting a fresh word clears stale symbols from the previous one.
          r_word <= WORD_W'(alignment_in);
          r_idx  <= CNT_W'(1);
          if (w_held_full && !w_push_ok) r_ovf <= 1'b1;
        end else begin
          r_word[w_lo +: BP_WIDTH] <= alignment_in;
          r_idx                    <= r_idx + 1'b1;
        end
      end
    end
  end

  aln_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Gate the head so unwritten FIFO storage never reaches the host.
  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? w_head[WORD_W-1:0]               : '0;
  assign out_count = out_valid ? w_head[WORD_W +: CNT_W]          : '0;
  assign out_last  = out_valid ? w_head[ENT_W-1]                  : 1'b0;
  assign total_len = r_len;
  assign overflow  = r_ovf;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alignment_collector.sv
// Directed scoreboard bench for alignment_collector.
module tb_alignment_collector;
  import alignment_collector_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
    logic [4:0]  cnt;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        tb_valid = 1'b0;
  logic [1:0]  alignment_in = 2'b00;
  logic        alignment_valid = 1'b0;
  logic        done = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_count;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] total_len;
  logic        overflow;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] pat [4] = '{32'h00000000, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF};

  alignment_collector dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .tb_valid        (tb_valid),
    .alignment_in    (alignment_in),
    .alignment_valid (alignment_valid),
    .done            (done),
    .out_data        (out_data),
    .out_count       (out_count),
    .out_last        (out_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .total_len       (total_len),
    .overflow        (overflow),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [31:0] m,
                             input logic [4:0] c, input logic l);
    exp_t e;
    e.data = d; e.mask = m; e.cnt = c; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_aln();
    tb_valid = 1'b1;
    step();
  endtask

  task automatic send(input logic [1:0] s);
    alignment_valid = 1'b1;
    alignment_in    = s;
    step();
    alignment_valid = 1'b0;
  endtask

  task automatic finish_aln(input logic with_sym, input logic [1:0] s);
    alignment_valid = with_sym;
    alignment_in    = s;
    done            = 1'b1;
    tb_valid        = 1'b0;
    step();
    alignment_valid = 1'b0;
    done            = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk({name, "_busy_drop"}, busy, 0);
  endtask

  // Scoreboard monitor: every host handshake consumes one expected word.
  always @(negedge clk) begin
    if (reset_i && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h count=%0d required=none", out_data, out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data",  out_data & e.mask, e.data & e.mask);
        chk("word_count", out_count, e.cnt);
        chk("word_last",  out_last, e.last);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", total_len, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", {out_last, out_count, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    step();

    // Symbols and done while idle are ignored
    send(ALN_DEL);
    send(ALN_INS);
    finish_aln(1'b0, 2'b00);
    step();
    chk("idle_len", total_len, 0);
    chk("idle_busy", busy, 0);

    // Single full word
    expect_word(32'hE4E4E4E4, 32'hFFFFFFFF, 5'd16, 1'b1);
    start_aln();
    for (int i = 0; i < 16; i++) send(2'(i));
    finish_aln(1'b0, 2'b00);
    wait_idle("single");
    chk("single_len", total_len, 16);

    // Partial word, last symbol arrives with done
    step();
    expect_word(32'h000007FF, 32'h00000FFF, 5'd6, 1'b1);
    start_aln();
    for (int i = 0; i < 5; i++) send(ALN_DEL);
    finish_aln(1'b1, ALN_MISMATCH);
    wait_idle("partial");
    chk("partial_len", total_len, 6);

    // Word boundary: 17 symbols, with an ignored tb_valid re-rise mid-stream
    step();
    expect_word(32'hAAAAAAAA, 32'hFFFFFFFF, 5'd16, 1'b0);
    expect_word(32'h00000002, 32'h00000003, 5'd1, 1'b1);
    start_aln();
    for (int i = 0; i < 17; i++) begin
      if (i == 8) begin
        tb_valid = 1'b0; step();
        tb_valid = 1'b1; step();
      end
      send(ALN_INS);
    end
    finish_aln(1'b0, 2'b00);
    wait_idle("boundary");
    chk("boundary_len", total_len, 17);

    // Empty alignment
    step();
    expect_word(32'h0, 32'h0, 5'd0, 1'b1);
    start_aln();
    finish_aln(1'b0, 2'b00);
    wait_idle("empty");
    chk("empty_len", total_len, 0);

    // Overflow: host stalled for 10 words; word 8 is dropped
    step();
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) expect_word(pat[w & 3], 32'hFFFFFFFF, 5'd16, 1'b0);
    expect_word(pat[1], 32'hFFFFFFFF, 5'd16, 1'b1);
    start_aln();
    for (int i = 0; i < 160; i++) begin
      send(2'((i / 16) & 3));
      if (i == 143) chk("ovf_before", overflow, 0);
      if (i == 144) chk("ovf_after", overflow, 1);
    end
    finish_aln(1'b0, 2'b00);
    repeat (5) step();
    chk("flush_stall_busy", busy, 1);
    chk("flush_stall_valid", out_valid, 1);
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    wait_idle("overflow");
    chk("ovf_len", total_len, 160);
    chk("ovf_hold", overflow, 1);

    // Mid-operation reset discards buffered words
    step();
    out_ready = 1'b0;
    start_aln();
    for (int i = 0; i < 20; i++) send(ALN_MISMATCH);
    chk("pre_rst_valid", out_valid, 1);
    reset_i  = 1'b0;
    tb_valid = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", total_len, 0);
    chk("mid_rst_data", out_data, 0);
    step();
    #2 reset_i = 1'b1;
    out_ready = 1'b1;
    step();
    expect_word(32'h00000023, 32'h0000003F, 5'd3, 1'b1);
    start_aln();
    chk("restart_busy", busy, 1);
    send(ALN_DEL);
    send(ALN_MATCH);
    send(ALN_INS);
    finish_aln(1'b0, 2'b00);
    wait_idle("restart");
    chk("restart_len", total_len, 3);

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
